// File: rtl/fifo_drain_serializer_pkg.sv
// Shared constants for the FIFO drain serializer: FSM encoding and beat-count helpers.
// The helpers let the top derive its beat count and beat-index width from its parameters.
package fifo_drain_serializer_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   // Number of OUT_WIDTH beats needed to carry one DATA_WIDTH entry.
   function automatic int numBeatsFor(input int dataWidth, input int outWidth);
      return (dataWidth + outWidth - 1) / outWidth;
   endfunction

   // Width of the beat index; never narrower than one bit.
   function automatic int beatIdxWidth(input int numBeats);
      return (numBeats <= 2) ? 1 : $clog2(numBeats);
   endfunction

   localparam int DEF_NUM_BEATS  = numBeatsFor(91, 32);
   localparam int DEF_BEAT_IDX_W = beatIdxWidth(DEF_NUM_BEATS);

endpackage

// File: rtl/fifo_drain_serializer.sv
// Pops entries from a show-ahead FIFO and streams each one as NUM_BEATS LSB-first
// ready/valid beats, chaining the next pop onto the final beat for zero-bubble operation.
module fifo_drain_serializer
   import fifo_drain_serializer_pkg::*;
#(
   parameter int DATA_WIDTH = 91,
   parameter int OUT_WIDTH  = 32,
   parameter int NUM_BEATS  = numBeatsFor(DATA_WIDTH, OUT_WIDTH),
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rstb,
   input  logic                  enable,
   input  logic                  fifoEmpty,
   input  logic [DATA_WIDTH-1:0] fifoData,
   output logic                  fifoRead,
   output logic                  outValid,
   input  logic                  outReady,
   output logic [OUT_WIDTH-1:0]  outData,
   output logic                  outLast,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  entriesSent
);

   localparam int IDX_W   = beatIdxWidth(NUM_BEATS);
   localparam int SHIFT_W = NUM_BEATS * OUT_WIDTH;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

   logic [0:0]           stateReg;
   logic [IDX_W-1:0]     beatIdxReg;
   logic [SHIFT_W-1:0]   shiftReg;
   logic [CNT_WIDTH-1:0] entriesSentReg;
   logic                 rstDoneReg;

   logic                 sending;
   logic                 lastBeat;
   logic                 beatXfer;
   logic [SHIFT_W-1:0]   loadWord;

   // Entry zero-extended to a whole number of beats so the top beat is padded.
   always_comb begin
      loadWord                   = '0;
      loadWord[DATA_WIDTH-1:0]   = fifoData;
   end

   assign sending  = (stateReg == ST_SEND);
   assign lastBeat = (beatIdxReg == LAST_IDX);
   assign beatXfer = sending && outReady;

   // rstDoneReg keeps the pop strobe quiet while rstb is low, since the state alone reads IDLE then.
   assign fifoRead = rstDoneReg && enable && !fifoEmpty && (!sending || (beatXfer && lastBeat));

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         stateReg       <= ST_IDLE;
         beatIdxReg     <= '0;
         shiftReg       <= '0;
         entriesSentReg <= '0;
         rstDoneReg     <= 1'b0;
      end else begin
         rstDoneReg <= 1'b1;
         if (fifoRead) begin
            shiftReg   <= loadWord;
            beatIdxReg <= '0;
            stateReg   <= ST_SEND;
         end else if (beatXfer) begin
            shiftReg <= shiftReg >> OUT_WIDTH;
            if (lastBeat) begin
               stateReg   <= ST_IDLE;
               beatIdxReg <= '0;
            end else begin
               beatIdxReg <= beatIdxReg + IDX_W'(1);
            end
         end
         if (beatXfer && lastBeat) begin
            entriesSentReg <= entriesSentReg + CNT_WIDTH'(1);
         end
      end
   end

   // The register is fully shifted out by the time the FSM idles, so outData reads zero there.
   assign outValid    = sending;
   assign busy        = sending;
   assign outLast     = sending && lastBeat;
   assign outData     = shiftReg[OUT_WIDTH-1:0];
   assign entriesSent = entriesSentReg;

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Self-checking bench: FIFO model plus an entry-to-beat scoreboard derived from the slicing rules.
module tb_fifo_drain_serializer;

   localparam int DW = 91;
   localparam int OW = 32;
   localparam int NB = 3;
   localparam int PW = NB * OW;

   typedef struct packed {
      logic          last;
      logic [OW-1:0] data;
   } beatT;

   logic          clk = 1'b0;
   logic          rstb = 1'b0;
   logic          enable = 1'b0;
   logic          fifoEmpty = 1'b1;
   logic [DW-1:0] fifoData = '0;
   logic          outReady = 1'b0;
   logic          fifoRead, outValid, outLast, busy;
   logic [OW-1:0] outData;
   logic [15:0]   entriesSent;
   logic          fifoReadW, outValidW, outLastW, busyW;
   logic [OW-1:0] outDataW;
   logic [3:0]    entriesSentW;

   int            tests = 0;
   int            fails = 0;
   logic [DW-1:0] fifoQ[$];
   beatT          expQ[$];
   logic [DW-1:0] pendEntry;
   bit            havePend = 0;
   int            sentModel = 0;
   logic [OW-1:0] obsBeats[$];
   logic          obsLast[$];

   fifo_drain_serializer #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .NUM_BEATS(NB), .CNT_WIDTH(16)) dut (
      .clk(clk), .rstb(rstb), .enable(enable), .fifoEmpty(fifoEmpty), .fifoData(fifoData),
      .fifoRead(fifoRead), .outValid(outValid), .outReady(outReady), .outData(outData),
      .outLast(outLast), .busy(busy), .entriesSent(entriesSent));

   fifo_drain_serializer #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .NUM_BEATS(NB), .CNT_WIDTH(4)) dutW (
      .clk(clk), .rstb(rstb), .enable(enable), .fifoEmpty(fifoEmpty), .fifoData(fifoData),
      .fifoRead(fifoReadW), .outValid(outValidW), .outReady(outReady), .outData(outDataW),
      .outLast(outLastW), .busy(busyW), .entriesSent(entriesSentW));

   always #5 clk = ~clk;

   // Show-ahead FIFO with a registered empty flag and head.
   always @(posedge clk) begin
      if (rstb && fifoRead && fifoQ.size() != 0) void'(fifoQ.pop_front());
      fifoEmpty <= (fifoQ.size() == 0);
      fifoData  <= (fifoQ.size() != 0) ? fifoQ[0] : '0;
   end

   function automatic void pushBeats(input logic [DW-1:0] e);
      logic [PW-1:0] p;
      beatT b;
      p = '0;
      p[DW-1:0] = e;
      for (int k = 0; k < NB; k++) begin
         b.data = p[k*OW +: OW];
         b.last = (k == NB - 1);
         expQ.push_back(b);
      end
   endfunction

   function automatic logic [DW-1:0] randEntry();
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      return r[DW-1:0];
   endfunction

   // Scoreboard: at each falling edge, predict valid/busy/pop and check the presented beat.
   always @(negedge clk) begin
      if (!rstb) begin
         expQ.delete();
         havePend  = 0;
         sentModel = 0;
      end else begin
         logic expHeld, expRead;
         if (havePend) begin
            pushBeats(pendEntry);
            havePend = 0;
         end
         expHeld = (expQ.size() != 0);
         expRead = enable && !fifoEmpty && (!expHeld || (outReady && expQ.size() == 1));
         tests++;
         if (outValid !== expHeld) begin
            fails++;
            $display("FAIL outValid: got %b want %b at %0t", outValid, expHeld, $time);
         end
         tests++;
         if (busy !== expHeld) begin
            fails++;
            $display("FAIL busy: got %b want %b at %0t", busy, expHeld, $time);
         end
         tests++;
         if (fifoRead !== expRead) begin
            fails++;
            $display("FAIL fifoRead: got %b want %b at %0t", fifoRead, expRead, $time);
         end
         tests++;
         if ({fifoReadW, outValidW, outLastW, busyW, outDataW} !== {fifoRead, outValid, outLast, busy, outData}) begin
            fails++;
            $display("FAIL narrowCounterInstance: outputs diverge at %0t", $time);
         end
         if (expHeld && outValid) begin
            tests++;
            if (outData !== expQ[0].data || outLast !== expQ[0].last) begin
               fails++;
               $display("FAIL beat: got %h/%b want %h/%b at %0t", outData, outLast, expQ[0].data, expQ[0].last, $time);
            end
            if (outReady) begin
               obsBeats.push_back(outData);
               obsLast.push_back(outLast);
               if (expQ[0].last) sentModel++;
               void'(expQ.pop_front());
            end
         end
         if (fifoRead && fifoQ.size() != 0) begin
            pendEntry = fifoQ[0];
            havePend  = 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      enable = 1'b0;
      rstb   = 1'b0;
      tick();
      tick();
      rstb = 1'b1;
      tick();
   endtask

   task automatic waitDrained(input int maxCycles);
      for (int i = 0; i < maxCycles; i++) begin
         @(posedge clk);
         #2;
         if (fifoQ.size() == 0 && expQ.size() == 0 && !havePend && fifoEmpty) return;
      end
      tests++;
      fails++;
      $display("FAIL drainTimeout: got %0d queued %0d pending beats want 0", fifoQ.size(), expQ.size());
   endtask

   task automatic waitValid(input int maxCycles);
      for (int i = 0; i < maxCycles; i++) begin
         @(negedge clk);
         if (outValid) return;
      end
      tests++;
      fails++;
      $display("FAIL validTimeout: got outValid=0 want 1 within %0d cycles", maxCycles);
   endtask

   task automatic test_reset();
      fifoQ.push_back(randEntry());
      enable = 1'b1;
      tick(); tick(); tick();
      tests++;
      if (fifoRead !== 1'b0) begin fails++; $display("FAIL resetFifoRead: got %b want 0", fifoRead); end
      tests++;
      if (outValid !== 1'b0) begin fails++; $display("FAIL resetOutValid: got %b want 0", outValid); end
      tests++;
      if (outData !== '0) begin fails++; $display("FAIL resetOutData: got %h want 0", outData); end
      tests++;
      if (outLast !== 1'b0) begin fails++; $display("FAIL resetOutLast: got %b want 0", outLast); end
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL resetBusy: got %b want 0", busy); end
      tests++;
      if (entriesSent !== 16'd0) begin fails++; $display("FAIL resetEntriesSent: got %0d want 0", entriesSent); end
      fifoQ.delete();
      enable = 1'b0;
      tick();
      rstb = 1'b1;
      tick(); tick();
   endtask

   task automatic test_single();
      // The 91-bit literal truncates bits [90:64] of 0x5DEADBEEF to 27'h6ADBEEF.
      logic [DW-1:0] e;
      e = {27'h6ADBEEF, 32'hCAFEF00D, 32'h12345678};
      obsBeats.delete();
      obsLast.delete();
      outReady = 1'b1;
      enable   = 1'b1;
      fifoQ.push_back(e);
      waitDrained(50);
      tests++;
      if (obsBeats.size() != 3) begin
         fails++;
         $display("FAIL singleBeatCount: got %0d want 3", obsBeats.size());
      end else begin
         tests++;
         if (obsBeats[0] !== 32'h12345678 || obsLast[0] !== 1'b0) begin fails++; $display("FAIL singleBeat0: got %h/%b want 12345678/0", obsBeats[0], obsLast[0]); end
         tests++;
         if (obsBeats[1] !== 32'hCAFEF00D || obsLast[1] !== 1'b0) begin fails++; $display("FAIL singleBeat1: got %h/%b want cafef00d/0", obsBeats[1], obsLast[1]); end
         tests++;
         if (obsBeats[2] !== 32'h06ADBEEF || obsLast[2] !== 1'b1) begin fails++; $display("FAIL singleBeat2: got %h/%b want 06adbeef/1", obsBeats[2], obsLast[2]); end
      end
      tests++;
      if (entriesSent !== 16'd1) begin fails++; $display("FAIL singleEntriesSent: got %0d want 1", entriesSent); end
   endtask

   task automatic test_back_to_back();
      int validCnt = 0, readCnt = 0, firstIdx = -1, lastIdx = -1;
      logic [15:0] base;
      base = entriesSent;
      outReady = 1'b1;
      enable   = 1'b1;
      for (int i = 0; i < 4; i++) fifoQ.push_back(randEntry());
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (outValid) begin
            validCnt++;
            if (firstIdx < 0) firstIdx = i;
            lastIdx = i;
         end
         if (fifoRead) readCnt++;
      end
      tests++;
      if (validCnt != 12 || lastIdx - firstIdx + 1 != 12) begin
         fails++;
         $display("FAIL b2bValidRun: got %0d valid over span %0d want 12 over 12", validCnt, lastIdx - firstIdx + 1);
      end
      tests++;
      if (readCnt != 4) begin fails++; $display("FAIL b2bReads: got %0d want 4", readCnt); end
      tests++;
      if (entriesSent !== base + 16'd4) begin fails++; $display("FAIL b2bEntriesSent: got %0d want %0d", entriesSent, base + 16'd4); end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] e;
      logic [PW-1:0] p;
      e = randEntry();
      p = '0;
      p[DW-1:0] = e;
      outReady = 1'b0;
      enable   = 1'b1;
      fifoQ.push_back(e);
      fifoQ.push_back(randEntry());
      waitValid(20);
      tick();
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++;
         if (outData !== p[OW +: OW] || outLast !== 1'b0 || outValid !== 1'b1) begin
            fails++;
            $display("FAIL bpHold: got %h/%b/%b want %h/0/1", outData, outLast, outValid, p[OW +: OW]);
         end
         tests++;
         if (fifoRead !== 1'b0) begin fails++; $display("FAIL bpNoRead: got %b want 0", fifoRead); end
      end
      tick();
      outReady = 1'b1;
      waitDrained(60);
   endtask

   task automatic test_enable_drop();
      int readCnt = 0;
      logic [15:0] base;
      base = entriesSent;
      outReady = 1'b1;
      enable   = 1'b1;
      fifoQ.push_back(randEntry());
      fifoQ.push_back(randEntry());
      waitValid(20);
      tick();
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (fifoRead) readCnt++;
      end
      tests++;
      if (readCnt != 0) begin fails++; $display("FAIL dropReads: got %0d want 0", readCnt); end
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL dropBusy: got %b want 0", busy); end
      tests++;
      if (entriesSent !== base + 16'd1) begin fails++; $display("FAIL dropEntriesSent: got %0d want %0d", entriesSent, base + 16'd1); end
      tick();
      enable = 1'b1;
      waitDrained(60);
   endtask

   task automatic test_wrap();
      doReset();
      enable = 1'b1;
      for (int i = 0; i < 17; i++) fifoQ.push_back(randEntry());
      for (int i = 0; i < 400 && sentModel < 17; i++) begin
         outReady = ($urandom_range(0, 3) != 0);
         tick();
      end
      outReady = 1'b1;
      waitDrained(60);
      tests++;
      if (entriesSentW !== 4'd1) begin fails++; $display("FAIL wrapCount: got %0d want 1", entriesSentW); end
      tests++;
      if (entriesSent !== 16'd17) begin fails++; $display("FAIL wrapWide: got %0d want 17", entriesSent); end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] e2;
      e2 = randEntry();
      outReady = 1'b1;
      enable   = 1'b1;
      fifoQ.push_back(randEntry());
      waitValid(20);
      tick();
      rstb = 1'b0;
      #1;
      tests++;
      if ({fifoRead, outValid, outLast, busy} !== 4'b0 || outData !== '0 || entriesSent !== 16'd0) begin
         fails++;
         $display("FAIL midReset: got rd=%b v=%b l=%b b=%b d=%h n=%0d want all 0", fifoRead, outValid, outLast, busy, outData, entriesSent);
      end
      enable = 1'b0;
      tick();
      rstb = 1'b1;
      fifoQ.push_back(e2);
      tick(); tick();
      obsBeats.delete();
      obsLast.delete();
      enable = 1'b1;
      waitDrained(50);
      tests++;
      if (obsBeats.size() != 3 || obsBeats[0] !== e2[OW-1:0]) begin
         fails++;
         $display("FAIL midResetRestart: got %0d beats first %h want 3 first %h", obsBeats.size(), (obsBeats.size() != 0) ? obsBeats[0] : 32'h0, e2[OW-1:0]);
      end
      tests++;
      if (entriesSent !== 16'd1) begin fails++; $display("FAIL midResetCount: got %0d want 1", entriesSent); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if (fifoQ.size() < 6 && $urandom_range(0, 2) == 0) fifoQ.push_back(randEntry());
         outReady = ($urandom_range(0, 3) != 0);
         enable   = ($urandom_range(0, 7) != 0);
         tick();
      end
      enable   = 1'b1;
      outReady = 1'b1;
      waitDrained(200);
      tests++;
      if (entriesSent !== 16'(sentModel)) begin fails++; $display("FAIL randomCount: got %0d want %0d", entriesSent, sentModel); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_enable_drop();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
